// File: rtl/ysyx_25030093_lsu_axi_master_if.sv
// AXI-lite style bus between the LSU master and the SRAM responder.
interface ysyx_25030093_lsu_axi_master_if #(
    parameter int WSTRB_W = 8
);
    logic [31:0]        M_araddr;
    logic               M_arvalid;
    logic               M_arready;
    logic [31:0]        M_rdata;
    logic               M_rvalid;
    logic               M_rready;
    logic [31:0]        M_awaddr;
    logic               M_awvalid;
    logic               M_awready;
    logic [31:0]        M_wdata;
    logic [WSTRB_W-1:0] M_wstrb;
    logic               M_wvalid;
    logic               M_wready;
    logic               M_bvalid;
    logic               M_bready;

    modport master (
        output M_araddr, M_arvalid, M_rready,
        output M_awaddr, M_awvalid, M_wdata, M_wstrb, M_wvalid, M_bready,
        input  M_arready, M_rdata, M_rvalid,
        input  M_awready, M_wready, M_bvalid
    );

    modport slave (
        input  M_araddr, M_arvalid, M_rready,
        input  M_awaddr, M_awvalid, M_wdata, M_wstrb, M_wvalid, M_bready,
        output M_arready, M_rdata, M_rvalid,
        output M_awready, M_wready, M_bvalid
    );
endinterface

// File: rtl/ysyx_25030093_lsu_axi_master.sv
// LSU to AXI-lite bus master, one transaction at a time, with watchdog.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module ysyx_25030093_lsu_axi_master #(
    parameter int WSTRB_W  = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    ysyx_25030093_lsu_axi_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, AR, R, WR, B, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, rdata_q, lane, load_ext;
    logic [1:0]  size_q;
    logic [3:0]  strb_q, strb_calc;
    logic        uns_q, wen_q, err_q, err_set;
    logic        aw_done, w_done;
    logic [7:0]  cnt;
    logic        accept, misalign, timeout, busy;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign req_ready      = (state == IDLE);
    assign bus.M_arvalid  = (state == AR);
    assign bus.M_rready   = (state == R);
    assign bus.M_awvalid  = (state == WR) && !aw_done;
    assign bus.M_wvalid   = (state == WR) && !w_done;
    assign bus.M_bready   = (state == B);
    assign bus.M_araddr   = {addr_q[31:2], 2'b00};
    assign bus.M_awaddr   = {addr_q[31:2], 2'b00};
    assign bus.M_wdata    = wdata_q;
    assign bus.M_wstrb    = {{(WSTRB_W-4){1'b0}}, strb_q};

    assign ar_hs   = bus.M_arvalid & bus.M_arready;
    assign r_hs    = bus.M_rvalid & bus.M_rready;
    assign aw_hs   = bus.M_awvalid & bus.M_awready;
    assign w_hs    = bus.M_wvalid & bus.M_wready;
    assign b_hs    = bus.M_bvalid & bus.M_bready;
    assign accept  = req_valid && (state == IDLE);
    assign busy    = (state == AR) || (state == R) ||
                     (state == WR) || (state == B);
    assign timeout = busy && (cnt == 8'(MAX_WAIT));

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = ((req_size == 2'd1) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Lanes pushed past byte 3 fall off the 4-bit strobe.
    always_comb begin
        unique case (req_size)
            2'd0:    strb_calc = 4'b0001 << req_addr[1:0];
            2'd1:    strb_calc = 4'b0011 << req_addr[1:0];
            default: strb_calc = 4'b1111;
        endcase
    end

    always_comb begin
        lane = rdata_q >> {addr_q[1:0], 3'b000};
        unique case (size_q)
            2'd0:    load_ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
            2'd1:    load_ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                if (misalign) begin
                    state_nxt = RESP;
                    err_set   = 1'b1;
                end else if (req_wen) begin
                    state_nxt = WR;
                end else begin
                    state_nxt = AR;
                end
            end
            AR: if (timeout) begin
                state_nxt = RESP;
                err_set   = 1'b1;
            end else if (ar_hs) begin
                state_nxt = R;
            end
            R: if (timeout) begin
                state_nxt = RESP;
                err_set   = 1'b1;
            end else if (r_hs) begin
                state_nxt = RESP;
            end
            WR: if (timeout) begin
                state_nxt = RESP;
                err_set   = 1'b1;
            end else if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                state_nxt = B;
            end
            B: if (timeout) begin
                state_nxt = RESP;
                err_set   = 1'b1;
            end else if (b_hs) begin
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 8'd0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            strb_q     <= 4'd0;
            rdata_q    <= 32'd0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            cnt <= (state_nxt != state || !busy) ? 8'd0 : cnt + 8'd1;
            aw_done <= (state == WR) && (aw_done | aw_hs);
            w_done  <= (state == WR) && (w_done | w_hs);
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wen_q   <= req_wen;
                wdata_q <= req_wdata << {req_addr[1:0], 3'b000};
                strb_q  <= strb_calc;
                err_q   <= err_set;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
            if (r_hs) begin
                rdata_q <= bus.M_rdata;
            end
            resp_valid <= (state == RESP);
            resp_err   <= (state == RESP) && err_q;
            resp_rdata <= (state == RESP && !err_q && !wen_q) ?
                          load_ext : 32'd0;
        end
    end
endmodule

// File: tb/tb_ysyx_25030093_lsu_axi_master.sv
// Directed self-checking bench for the LSU AXI-lite master.
// Build with LSU_MISALIGN_CHECK_EN to exercise the misalign abort path.
module tb_ysyx_25030093_lsu_axi_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int failures = 0;

    ysyx_25030093_lsu_axi_master_if #(.WSTRB_W(8)) bus ();

    ysyx_25030093_lsu_axi_master #(.WSTRB_W(8), .MAX_WAIT(255)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp;
    } ld_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] exp_data;
        logic [31:0] exp_strb;
    } st_vec_t;

    ld_vec_t lv [7] = '{
        '{32'h8000_0003, 2'd0, 1'b0, 32'hFFFF_FF80},
        '{32'h8000_0002, 2'd1, 1'b1, 32'h0000_80FF},
        '{32'h8000_0002, 2'd1, 1'b0, 32'hFFFF_80FF},
        '{32'h8000_0001, 2'd0, 1'b1, 32'h0000_0012},
        '{32'h8000_0000, 2'd0, 1'b0, 32'h0000_0034},
        '{32'h8000_0004, 2'd2, 1'b0, 32'h80FF_1234},
        '{32'h8000_0008, 2'd3, 1'b0, 32'h80FF_1234}
    };

    st_vec_t sv [3] = '{
        '{32'h8000_0102, 32'h0000_ABCD, 2'd1, 32'hABCD_0000, 32'h0C},
        '{32'h8000_0101, 32'h0000_005A, 2'd0, 32'h0000_5A00, 32'h02},
        '{32'h8000_0100, 32'h1122_3344, 2'd2, 32'h1122_3344, 32'h0F}
    };

    int          lat;
    int          n;
    logic [31:0] rd;
    logic        er;
    logic        seen;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge after acceptance.
    task automatic issue(input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input logic uns);
        check("req_ready", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int l, output logic [31:0] d,
                             output logic e);
        l = 1;
        while (!resp_valid && l < 400) begin
            @(negedge clk);
            l++;
        end
        check("resp_seen", {31'd0, resp_valid}, 32'd1);
        d = resp_rdata;
        e = resp_err;
        @(negedge clk);
        check("resp_pulse", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        bus.M_arready = 1'b1;
        bus.M_rvalid  = 1'b1;
        bus.M_rdata   = 32'h80FF_1234;
        bus.M_awready = 1'b1;
        bus.M_wready  = 1'b1;
        bus.M_bvalid  = 1'b1;

        #2;
        check("rst_arvalid", {31'd0, bus.M_arvalid}, 32'd0);
        check("rst_awvalid", {31'd0, bus.M_awvalid}, 32'd0);
        check("rst_rready", {31'd0, bus.M_rready}, 32'd0);
        check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_addr", bus.M_araddr, 32'd0);
        check("rst_wstrb", {24'd0, bus.M_wstrb}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (lv[i]) begin
            issue(1'b0, lv[i].addr, 32'd0, lv[i].size, lv[i].uns);
            check($sformatf("ld%0d_arvalid", i), {31'd0, bus.M_arvalid}, 32'd1);
            check($sformatf("ld%0d_araddr", i), bus.M_araddr,
                  lv[i].addr & 32'hFFFF_FFFC);
            wait_resp(lat, rd, er);
            check($sformatf("ld%0d_rdata", i), rd, lv[i].exp);
            check($sformatf("ld%0d_err", i), {31'd0, er}, 32'd0);
            if (i == 0) check("ld_latency", lat, 4);
        end

        foreach (sv[i]) begin
            issue(1'b1, sv[i].addr, sv[i].wdata, sv[i].size, 1'b0);
            check($sformatf("st%0d_valids", i),
                  {30'd0, bus.M_awvalid, bus.M_wvalid}, 32'd3);
            check($sformatf("st%0d_awaddr", i), bus.M_awaddr,
                  sv[i].addr & 32'hFFFF_FFFC);
            check($sformatf("st%0d_wdata", i), bus.M_wdata, sv[i].exp_data);
            check($sformatf("st%0d_wstrb", i), {24'd0, bus.M_wstrb},
                  sv[i].exp_strb);
            wait_resp(lat, rd, er);
            check($sformatf("st%0d_rdata", i), rd, 32'd0);
            check($sformatf("st%0d_err", i), {31'd0, er}, 32'd0);
        end

`ifndef LSU_MISALIGN_CHECK_EN
        issue(1'b1, 32'h8000_0103, 32'h0000_ABCD, 2'd1, 1'b0);
        check("st_trunc_wdata", bus.M_wdata, 32'hCD00_0000);
        check("st_trunc_wstrb", {24'd0, bus.M_wstrb}, 32'h08);
        wait_resp(lat, rd, er);
        check("st_trunc_err", {31'd0, er}, 32'd0);
`endif

        bus.M_awready = 1'b0;
        issue(1'b1, 32'h8000_0200, 32'h1122_3344, 2'd2, 1'b0);
        check("skew_both", {30'd0, bus.M_awvalid, bus.M_wvalid}, 32'd3);
        @(negedge clk);
        check("skew_w_drop", {30'd0, bus.M_awvalid, bus.M_wvalid}, 32'd2);
        check("skew_no_b1", {31'd0, bus.M_bready}, 32'd0);
        @(negedge clk);
        check("skew_hold", {30'd0, bus.M_awvalid, bus.M_wvalid}, 32'd2);
        check("skew_no_b2", {31'd0, bus.M_bready}, 32'd0);
        bus.M_awready = 1'b1;
        @(negedge clk);
        check("skew_aw_drop", {31'd0, bus.M_awvalid}, 32'd0);
        check("skew_bready", {31'd0, bus.M_bready}, 32'd1);
        wait_resp(lat, rd, er);
        check("skew_err", {31'd0, er}, 32'd0);

        bus.M_arready = 1'b0;
        issue(1'b0, 32'h8000_0010, 32'd0, 2'd2, 1'b0);
        n = 0;
        while (bus.M_arvalid && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("to_len", {31'd0, (n >= 255 && n <= 256)}, 32'd1);
        wait_resp(lat, rd, er);
        check("to_err", {31'd0, er}, 32'd1);
        check("to_rdata", rd, 32'd0);
        seen = 1'b0;
        repeat (5) begin
            seen |= resp_valid | bus.M_rready;
            @(negedge clk);
        end
        check("to_late_r", {31'd0, seen}, 32'd0);
        bus.M_arready = 1'b1;

        bus.M_rvalid = 1'b0;
        issue(1'b0, 32'h8000_0020, 32'd0, 2'd2, 1'b0);
        @(negedge clk);
        check("mid_r_rready", {31'd0, bus.M_rready}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_r_clear",
              {29'd0, bus.M_rready, bus.M_arvalid, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.M_rvalid = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            seen |= resp_valid;
            @(negedge clk);
        end
        check("mid_r_noresp", {31'd0, seen}, 32'd0);
        check("mid_r_ready", {31'd0, req_ready}, 32'd1);

`ifdef LSU_MISALIGN_CHECK_EN
        issue(1'b0, 32'h8000_0001, 32'd0, 2'd2, 1'b0);
        seen = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            seen |= bus.M_arvalid;
            @(negedge clk);
            lat++;
        end
        check("mis_lat", lat, 2);
        check("mis_err", {31'd0, resp_err}, 32'd1);
        check("mis_rdata", resp_rdata, 32'd0);
        check("mis_no_ar", {31'd0, seen}, 32'd0);
`else
        issue(1'b0, 32'h8000_0001, 32'd0, 2'd2, 1'b0);
        check("mis_ar_issued", {31'd0, bus.M_arvalid}, 32'd1);
        wait_resp(lat, rd, er);
        check("mis_rdata", rd, 32'h0080_FF12);
        check("mis_err", {31'd0, er}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_25030093_lsu_axi_master.md
Name: ysyx_25030093_lsu_axi_master

Overview:
- Bus initiator between the core's load/store unit and the AXI-lite style SRAM responder.
- Accepts one load or store request at a time and drives AR/R or AW/W/B channels.
- Loads: extracts and sign/zero-extends bytes and halfwords. Stores: generates byte-lane data and strobes.
- Returns a single-cycle completion pulse to the core; no outstanding-transaction overlap.

Parameters:
- WSTRB_W, 8, width of bus write strobe; only bits [3:0] ever set, upper bits driven 0.
- MAX_WAIT, 255, cycles any single channel may wait for the responder before the transaction aborts with resp_err; 8-bit counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core request valid
- req_ready  output  1  master can accept request (high only in IDLE)
- req_wen  input  1  1=store, 0=load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- req_size  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- req_unsigned  input  1  load zero-extend when 1
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  aligned, extended load data (0 for stores)
- resp_err  output  1  valid with resp_valid; timeout or misalign abort
- M_araddr  output  32  read address, word-aligned (addr[1:0]=0)
- M_arvalid  output  1  read address valid
- M_arready  input  1  responder ready
- M_rdata  input  32  read data
- M_rvalid  input  1  read data valid
- M_rready  output  1  read data ready
- M_awaddr  output  32  write address, word-aligned
- M_awvalid  output  1  write address valid
- M_awready  input  1  responder ready
- M_wdata  output  32  lane-shifted store data
- M_wstrb  output  WSTRB_W  byte strobes
- M_wvalid  output  1  write data valid
- M_wready  input  1  responder ready
- M_bvalid  input  1  write response valid
- M_bready  output  1  write response ready

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all valid/ready outputs 0; resp_valid=0, resp_err=0; resp_rdata=0; addresses/data/strobe 0; wait counter 0. Reset mid-transaction abandons it; no resp_valid afterwards.
- FSM states: IDLE, AR, R, WR, B, RESP.
- IDLE: req_ready=1. On req_valid, latch addr, size, unsigned, offset=addr[1:0] and wdata.
  - Load → AR with M_arvalid=1.
  - Store → WR with M_awvalid=M_wvalid=1.
- AR: hold M_arvalid and M_araddr stable until M_arvalid&M_arready sampled high. Then M_arvalid=0 and M_rready=1 next cycle; go to R.
- R: on M_rvalid&M_rready, capture M_rdata, drop M_rready, go to RESP.
- WR: AW and W complete independently.
  - Each valid drops the cycle after its own handshake; done flags are kept.
  - When both are done, M_bready=1; go to B. Handshakes in the same cycle count for both.
- B: on M_bvalid&M_bready, drop M_bready; go to RESP.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err; next state IDLE. Minimum load latency: request accept to resp_valid = 4 cycles against a zero-wait responder.
- Load extraction: lane = rdata >> (8*offset).
  - Byte: bits [7:0], sign-extend from bit7 unless unsigned.
  - Half: bits [15:0], sign-extend from bit15 unless unsigned.
  - Word: full lane.
- Store strobes/data: M_wdata = req_wdata << (8*offset).
  - Byte: 4'b0001<<offset.
  - Half: 4'b0011<<offset.
  - Word: 4'b1111.
- Watchdog: counter clears on every state change and counts while in AR, R, WR or B. At MAX_WAIT it drops all bus valids/readies, goes to RESP with resp_err=1 and resp_rdata=0.
- req_valid is ignored outside IDLE. Late M_rvalid/M_bvalid arriving after a timeout is ignored in IDLE.

Optional Feature:
- LSU_MISALIGN_CHECK_EN defined: in IDLE, a half with offset[0]=1, or a word with offset!=0, issues no bus traffic and goes directly to RESP with resp_err=1 (latency 2 cycles).
- Undefined: misaligned half/word issue normally; lanes beyond byte 3 are truncated (strobe bits shifted out of [3:0] are dropped).

Test Plan:
- Load byte: addr=0x80000003, signed, responder rdata=0x80FF1234, zero waits → M_araddr=0x80000000, resp_rdata=0xFFFFFF80, resp_err=0, resp_valid 4 cycles after accept.
- Store half: addr=0x80000102, wdata=0x0000ABCD → M_awaddr=0x80000100, M_wdata=0xABCD0000, M_wstrb=0x0C, one resp_valid, resp_err=0.
- Skewed write: M_awready 3 cycles late, M_wready immediate → M_wvalid drops after its handshake, M_awvalid held, M_bready asserted only after both complete.
- Timeout: load with M_arready tied 0 → M_arvalid drops after 255 waiting cycles, resp_valid=1, resp_err=1, resp_rdata=0.
- Reset mid-R: rst_n low while in R → outputs zero immediately; after release, req_ready=1 and no spurious resp_valid.
- With LSU_MISALIGN_CHECK_EN: word load at 0x80000001 → no M_arvalid, resp_err=1 two cycles after accept.
